// File: rtl/plane_bomb_pkg.sv
// Shared types and constants for the enemy-plane bomb and its sprite addressing.
package plane_bomb_pkg;

    localparam int unsigned COORD_W           = 10;
    localparam int unsigned CMP_W             = 11;
    localparam int unsigned ADDR_W            = 16;
    localparam int unsigned CNT_W             = 5;
    localparam int unsigned VEL_W             = 4;

    localparam int unsigned BOMB_W            = 12;
    localparam int unsigned BOMB_H            = 16;
    localparam int unsigned START_DY          = 19;
    localparam int unsigned FALL_STEP         = 2;
    localparam int unsigned GROUND_Y          = 440;
    localparam int unsigned CHAR_W            = 32;
    localparam int unsigned CHAR_H            = 48;
    localparam int unsigned EXPLODE_FRAMES    = 20;
    localparam int unsigned MAX_VEL           = 8;
    localparam int unsigned BOMB_SPRITE_WORDS = BOMB_W * BOMB_H;

    typedef enum logic [1:0] {BOMB_IDLE, BOMB_FALL, BOMB_EXPLODE} bomb_state_t;

    // Screen-coordinate add that pins at the top of the range instead of wrapping.
    function automatic logic [COORD_W-1:0] sat_add(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
        logic [CMP_W-1:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CMP_W-1] ? '1 : s[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/plane_bomb_if.sv
// Launch/explored handshake between the enemy plane (master) and its bomb (slave).
interface plane_bomb_if;
    import plane_bomb_pkg::*;

    logic               launch;
    logic [COORD_W-1:0] start_x;
    logic [COORD_W-1:0] start_y;
    logic               explored;

    modport master (output launch, start_x, start_y, input explored);
    modport slave  (input launch, start_x, start_y, output explored);
endinterface

// File: rtl/frame_edge_det.sv
// Turns the slow frame strobe into a single-Clk pulse on each rising edge.
module frame_edge_det (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic fe
);
    logic sync_q;
    logic prev_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            fe     <= 1'b0;
        end else begin
            sync_q <= frame_clk;
            prev_q <= sync_q;
            fe     <= sync_q & ~prev_q;
        end
    end
endmodule

// File: rtl/plane_bomb.sv
// Enemy-plane bomb: launch capture, per-frame fall, hit/ground detonation, sprite addressing.
// Optional PLANE_BOMB_GRAVITY_EN replaces the constant fall step with an accelerating one.
module plane_bomb
    import plane_bomb_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    plane_bomb_if.slave        bus,
    input  logic [COORD_W-1:0] char_x,
    input  logic [COORD_W-1:0] char_y,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    output logic               is_bomb,
    output logic [ADDR_W-1:0]  addr,
    output logic [COORD_W-1:0] bomb_x,
    output logic [COORD_W-1:0] bomb_y,
    output logic               hit_char
);

    bomb_state_t        state, state_n;
    logic               fe;
    logic [COORD_W-1:0] bx_n, by_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               hit_n;
    logic               overlap;
    logic               grounded;
    logic [COORD_W-1:0] step;
    logic [CMP_W-1:0]   bx_w, by_w, cx_w, cy_w;
    logic [COORD_W-1:0] dx, dy;
    logic [ADDR_W-1:0]  off;

`ifdef PLANE_BOMB_GRAVITY_EN
    logic [VEL_W-1:0]   vel, vel_n;
    logic [1:0]         vcnt, vcnt_n;
    assign step = COORD_W'(vel);
`else
    assign step = COORD_W'(FALL_STEP);
`endif

    frame_edge_det u_fe (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .fe        (fe)
    );

    // Widened copies so box edges past 1023 compare correctly.
    assign bx_w = CMP_W'(bomb_x);
    assign by_w = CMP_W'(bomb_y);
    assign cx_w = CMP_W'(char_x);
    assign cy_w = CMP_W'(char_y);

    assign overlap  = (bx_w < cx_w + CMP_W'(CHAR_W)) && (cx_w < bx_w + CMP_W'(BOMB_W)) &&
                      (by_w < cy_w + CMP_W'(CHAR_H)) && (cy_w < by_w + CMP_W'(BOMB_H));
    assign grounded = (by_w + CMP_W'(BOMB_H)) >= CMP_W'(GROUND_Y);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= BOMB_IDLE;
            bus.explored <= 1'b1;
            bomb_x       <= '0;
            bomb_y       <= '0;
            hit_char     <= 1'b0;
            cnt          <= '0;
`ifdef PLANE_BOMB_GRAVITY_EN
            vel          <= '0;
            vcnt         <= '0;
`endif
        end else begin
            state        <= state_n;
            bus.explored <= (state_n == BOMB_IDLE);
            bomb_x       <= bx_n;
            bomb_y       <= by_n;
            hit_char     <= hit_n;
            cnt          <= cnt_n;
`ifdef PLANE_BOMB_GRAVITY_EN
            vel          <= vel_n;
            vcnt         <= vcnt_n;
`endif
        end
    end

    // Collision tests see the position before this frame's move; detonation freezes it.
    always_comb begin
        state_n = state;
        bx_n    = bomb_x;
        by_n    = bomb_y;
        hit_n   = 1'b0;
        cnt_n   = cnt;
`ifdef PLANE_BOMB_GRAVITY_EN
        vel_n   = vel;
        vcnt_n  = vcnt;
`endif
        case (state)
            BOMB_IDLE: begin
                if (bus.launch) begin
                    bx_n    = bus.start_x;
                    by_n    = sat_add(bus.start_y, COORD_W'(START_DY));
                    cnt_n   = '0;
                    state_n = BOMB_FALL;
`ifdef PLANE_BOMB_GRAVITY_EN
                    vel_n   = VEL_W'(1);
                    vcnt_n  = '0;
`endif
                end
            end
            BOMB_FALL: begin
                if (fe) begin
                    if (overlap) begin
                        hit_n   = 1'b1;
                        cnt_n   = '0;
                        state_n = BOMB_EXPLODE;
                    end else if (grounded) begin
                        cnt_n   = '0;
                        state_n = BOMB_EXPLODE;
                    end else begin
                        by_n = sat_add(bomb_y, step);
`ifdef PLANE_BOMB_GRAVITY_EN
                        vcnt_n = vcnt + 2'd1;
                        if (vcnt == 2'd3 && vel < VEL_W'(MAX_VEL)) begin
                            vel_n = vel + VEL_W'(1);
                        end
`endif
                    end
                end
            end
            BOMB_EXPLODE: begin
                if (fe) begin
                    if (cnt == CNT_W'(EXPLODE_FRAMES - 1)) begin
                        cnt_n   = '0;
                        state_n = BOMB_IDLE;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_n = BOMB_IDLE;
        endcase
    end

    // Pixel lookup; the unsigned wrap of the differences doubles as the left/top bound.
    assign dx      = DrawX - bomb_x;
    assign dy      = DrawY - bomb_y;
    assign is_bomb = (state != BOMB_IDLE) && (dx < COORD_W'(BOMB_W)) && (dy < COORD_W'(BOMB_H));

    always_comb begin
        off = '0;
        if (state == BOMB_EXPLODE) begin
            off = (cnt < CNT_W'(EXPLODE_FRAMES / 2)) ? ADDR_W'(BOMB_SPRITE_WORDS)
                                                      : ADDR_W'(2 * BOMB_SPRITE_WORDS);
        end
    end

    assign addr = ADDR_W'(dy) * ADDR_W'(BOMB_W) + ADDR_W'(dx) + off;

endmodule

// File: tb/tb_plane_bomb.sv
// Bench for plane_bomb: frame-level behavioural model, per-cycle compare, directed scenarios.
module tb_plane_bomb;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [9:0] char_x = 10'd600;
    logic [9:0] char_y = 10'd0;
    logic [9:0] DrawX = 10'd0;
    logic [9:0] DrawY = 10'd0;
    logic       is_bomb;
    logic [15:0] addr;
    logic [9:0] bomb_x, bomb_y;
    logic       hit_char;

    plane_bomb_if bus ();

    plane_bomb dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .bus       (bus),
        .char_x    (char_x),
        .char_y    (char_y),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .is_bomb   (is_bomb),
        .addr      (addr),
        .bomb_x    (bomb_x),
        .bomb_y    (bomb_y),
        .hit_char  (hit_char)
    );

    always #5 Clk = ~Clk;

    // Model: 0 = waiting, 1 = falling, 2 = exploding (m_boom = frames spent exploding).
    int m_state = 0;
    int m_x = 0, m_y = 0, m_boom = 0, m_moves = 0, m_hits = 0;
    int hit_seen = 0;
    int cyc = 0, quiet_until = 0;
    int n_cmp = 0, n_bad = 0;
    bit hit_prev = 1'b0;
    bit pin_mode = 1'b0;
    int pin_dx = 0, pin_dy = 0;
    int ox [8] = '{0, 11, 12, 0, -1, 5, 6, 11};
    int oy [8] = '{0, 15, 0, 16, 5, -1, 8, 0};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_frame();
        int sp;
        if (m_state == 1) begin
            if (m_x < int'(char_x) + 32 && int'(char_x) < m_x + 12 &&
                m_y < int'(char_y) + 48 && int'(char_y) < m_y + 16) begin
                m_state = 2; m_boom = 0; m_hits++;
            end else if (m_y + 16 >= 440) begin
                m_state = 2; m_boom = 0;
            end else begin
`ifdef PLANE_BOMB_GRAVITY_EN
                sp = 1 + m_moves / 4;
                if (sp > 8) sp = 8;
`else
                sp = 2;
`endif
                m_y = m_y + sp;
                if (m_y > 1023) m_y = 1023;
                m_moves++;
            end
        end else if (m_state == 2) begin
            m_boom++;
            if (m_boom == 20) m_state = 0;
        end
    endtask

    task automatic frame();
        @(posedge Clk); #1;
        frame_clk = 1'b1;
        model_frame();
        quiet_until = cyc + 6;
        repeat (4) @(posedge Clk);
        #1 frame_clk = 1'b0;
        repeat (3) @(posedge Clk);
    endtask

    task automatic do_launch(input int x, input int y);
        @(posedge Clk); #1;
        bus.launch  = 1'b1;
        bus.start_x = 10'(x);
        bus.start_y = 10'(y);
        if (m_state == 0) begin
            m_state = 1; m_x = x; m_y = y + 19; m_moves = 0;
            if (m_y > 1023) m_y = 1023;
        end
        quiet_until = cyc + 3;
        @(posedge Clk); #1;
        bus.launch = 1'b0;
    endtask

    // Pixel driver: sweeps box-edge probes around the model position, or holds a pinned pixel.
    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge Clk); #1;
            if (pin_mode) begin
                DrawX = 10'(m_x + pin_dx);
                DrawY = 10'(m_y + pin_dy);
            end else begin
                DrawX = 10'(m_x + ox[k]);
                DrawY = 10'(m_y + oy[k]);
                k = (k + 1) % 8;
            end
        end
    end

    // Per-cycle compare against the model once the DUT has had time to react.
    initial begin
        int dxw, dyw, off;
        bit ins;
        forever begin
            @(negedge Clk);
            cyc++;
            if (hit_char === 1'b1) begin
                hit_seen++;
                check("hit_char_width", int'(hit_prev), 0);
            end
            hit_prev = (hit_char === 1'b1);
            if (cyc >= quiet_until) begin
                dxw = (int'(DrawX) - m_x + 1024) % 1024;
                dyw = (int'(DrawY) - m_y + 1024) % 1024;
                ins = (m_state != 0) && dxw < 12 && dyw < 16;
                off = (m_state == 2) ? ((m_boom < 10) ? 192 : 384) : 0;
                check("explored", int'(bus.explored), (m_state == 0) ? 1 : 0);
                check("bomb_x", int'(bomb_x), m_x);
                check("bomb_y", int'(bomb_y), m_y);
                check("is_bomb", int'(is_bomb), ins ? 1 : 0);
                if (ins) check("addr", int'(addr), dyw * 12 + dxw + off);
            end
        end
    end

    initial begin
        int hits0;
        bus.launch  = 1'b0;
        bus.start_x = '0;
        bus.start_y = '0;

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_explored", int'(bus.explored), 1);
        check("rst_bomb_x", int'(bomb_x), 0);
        check("rst_bomb_y", int'(bomb_y), 0);
        check("rst_is_bomb", int'(is_bomb), 0);
        check("rst_hit_char", int'(hit_char), 0);
        @(posedge Clk); #1 Reset = 1'b0;

        // Launch capture and fall
        do_launch(300, 20);
        @(negedge Clk);
        check("t1_bomb_x", int'(bomb_x), 300);
        check("t1_bomb_y", int'(bomb_y), 39);
        check("t1_explored", int'(bus.explored), 0);
        repeat (10) frame();
        @(negedge Clk);
`ifdef PLANE_BOMB_GRAVITY_EN
        check("t1_y_10fe", int'(bomb_y), 57);
`else
        check("t1_y_10fe", int'(bomb_y), 59);
`endif

        // Launch while falling is ignored
        do_launch(100, 200);
        @(negedge Clk);
        check("t4_bomb_x", int'(bomb_x), 300);
        repeat (2) frame();
        @(negedge Clk);
        check("t6_y_12fe", int'(bomb_y), 63);

        // Character in the path
        char_x = 10'd294;
        char_y = 10'd100;
        hits0 = hit_seen;
        for (int i = 0; i < 60 && m_state == 1; i++) frame();
        @(negedge Clk);
        check("t2_hits", hit_seen - hits0, 1);
        check("t2_model_hits", m_hits, 1);
`ifndef PLANE_BOMB_GRAVITY_EN
        check("t2_hit_y", int'(bomb_y), 85);
`endif
        check("t2_explored", int'(bus.explored), 0);
        repeat (19) frame();
        @(negedge Clk);
        check("t2_explored_19fe", int'(bus.explored), 0);
        frame();
        @(negedge Clk);
        check("t2_explored_20fe", int'(bus.explored), 1);
        check("t2_hits_after", hit_seen - hits0, 1);

        // Ground detonation and explosion sprite offsets
        char_x = 10'd600;
        char_y = 10'd0;
        hits0 = hit_seen;
        do_launch(300, 20);
        for (int i = 0; i < 400 && m_state == 1; i++) frame();
        pin_mode = 1'b1; pin_dx = 0; pin_dy = 0;
        repeat (2) @(negedge Clk);
        check("t3_addr_first_half", int'(addr), 192);
        check("t3_is_bomb", int'(is_bomb), 1);
`ifndef PLANE_BOMB_GRAVITY_EN
        check("t3_ground_y", int'(bomb_y), 425);
`endif
        check("t3_no_hit", hit_seen - hits0, 0);
        pin_dx = 5; pin_dy = 3;
        repeat (9) frame();
        @(negedge Clk);
        check("t3_addr_9fe", int'(addr), 3 * 12 + 5 + 192);
        frame();
        @(negedge Clk);
        check("t3_addr_second_half", int'(addr), 3 * 12 + 5 + 384);
        repeat (9) frame();
        @(negedge Clk);
        check("t3_explored_19fe", int'(bus.explored), 0);
        frame();
        @(negedge Clk);
        check("t3_explored_20fe", int'(bus.explored), 1);
        check("t3_is_bomb_idle", int'(is_bomb), 0);
        pin_mode = 1'b0;

        // Asynchronous reset in mid-fall
        do_launch(200, 50);
        repeat (3) frame();
        pin_mode = 1'b1; pin_dx = 0; pin_dy = 0;
        repeat (2) @(negedge Clk);
        check("t5_is_bomb_pre", int'(is_bomb), 1);
        @(posedge Clk); #3;
        Reset = 1'b1;
        m_state = 0; m_x = 0; m_y = 0; m_boom = 0;
        #1;
        check("t5_explored", int'(bus.explored), 1);
        check("t5_is_bomb", int'(is_bomb), 0);
        check("t5_bomb_y", int'(bomb_y), 0);
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        pin_mode = 1'b0;
        repeat (4) @(posedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
